// File: rtl/otter_mmio_pkg.sv
// Shared address map and constants for the OTTER MMIO hub.
// Contents:
//   IN_BASE / OUT_BASE / STRIDE : channel address map; channel n lives at BASE + n*STRIDE
//   IRQ_PEND_AD / IRQ_MASK_AD   : interrupt pending (write-1-to-clear) and mask registers
//   WARMUP_CYCLES               : edges after reset release before change detection is trusted
//   chan_addr()                 : address of channel idx above a given base
package otter_mmio_pkg;

  localparam logic [31:0] IN_BASE     = 32'h1100_0000;
  localparam logic [31:0] OUT_BASE    = 32'h1108_0000;
  localparam logic [31:0] STRIDE      = 32'h0004_0000;
  localparam logic [31:0] IRQ_PEND_AD = 32'h1120_0000;
  localparam logic [31:0] IRQ_MASK_AD = 32'h1124_0000;

  localparam int WARMUP_CYCLES = 3;

  function automatic logic [31:0] chan_addr(input logic [31:0] base, input int idx);
    return base + (STRIDE * 32'(idx));
  endfunction

endpackage

// File: rtl/mmio_in_channel.sv
// One input channel of the MMIO hub: two-flop synchroniser followed by a
// "previous value" register used for change detection.
// Ports:
//   CLK, RST : clock and synchronous active-high reset
//   pins     : raw asynchronous input bits
//   sync     : synchronised value (second flop), safe to read on the bus
//   change   : high while the synchronised value differs from the previous one
module mmio_in_channel #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] pins,
  output logic [W-1:0] sync,
  output logic         change
);

  logic [W-1:0] sync_p0;
  logic [W-1:0] sync_p1;
  logic [W-1:0] prev_p2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
    end else begin
      // stage 0: first synchroniser flop (may go metastable)
      sync_p0 <= pins;
      // stage 1: second synchroniser flop, the value seen by the MCU
      sync_p1 <= sync_p0;
      // stage 2: last accepted value, compared against stage 1
      prev_p2 <= sync_p1;
    end
  end

  assign sync   = sync_p1;
  assign change = (sync_p1 != prev_p2);

endmodule

// File: rtl/otter_mmio_hub.sv
// Memory-mapped I/O hub between the OTTER IOBUS and board peripherals.
// N_IN synchronised input channels with change detection, N_OUT output
// registers, and an interrupt pending/mask pair driving a registered intr.
// Ports:
//   CLK, RST   : CPU clock, synchronous active-high reset
//   iobus_addr : MCU address (exact-match decode)
//   iobus_out  : MCU write data
//   iobus_wr   : MCU write strobe
//   iobus_in   : combinational read data to the MCU
//   in_data    : raw inputs, channel i at [i*IN_W +: IN_W]
//   out_data   : output registers, channel j at [j*OUT_W +: OUT_W]
//   intr       : registered interrupt request (level or one-cycle pulse)
module otter_mmio_hub
  import otter_mmio_pkg::*;
#(
  parameter int N_IN      = 2,
  parameter int IN_W      = 16,
  parameter int N_OUT     = 2,
  parameter int OUT_W     = 16,
  parameter int IRQ_PULSE = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [31:0]            iobus_addr,
  input  logic [31:0]            iobus_out,
  input  logic                   iobus_wr,
  output logic [31:0]            iobus_in,
  input  logic [N_IN*IN_W-1:0]   in_data,
  output logic [N_OUT*OUT_W-1:0] out_data,
  output logic                   intr
);

  localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);

  logic [N_IN*IN_W-1:0]   sync_all;
  logic [N_IN-1:0]        change;
  logic [N_IN-1:0]        in_hit;
  logic [N_OUT-1:0]       out_hit;
  logic                   pend_hit;
  logic                   mask_hit;
  logic [N_OUT*OUT_W-1:0] out_q;
  logic [N_IN-1:0]        pend;
  logic [N_IN-1:0]        mask;
  logic [N_IN-1:0]        pend_set;
  logic [N_IN-1:0]        pend_clr;
  logic [WARM_W-1:0]      warm_cnt;
  logic                   warm_done;
  logic                   irq_any;
  logic                   irq_any_q;

  genvar g;
  generate
    for (g = 0; g < N_IN; g++) begin : g_in
      mmio_in_channel #(.W(IN_W)) u_in (
        .CLK    (CLK),
        .RST    (RST),
        .pins   (in_data[g*IN_W +: IN_W]),
        .sync   (sync_all[g*IN_W +: IN_W]),
        .change (change[g])
      );
    end
  endgenerate

  // With many channels the input/output windows can run into each other and
  // into the IRQ registers; the IRQ registers win, then outputs, then inputs.
  always_comb begin
    pend_hit = (iobus_addr == IRQ_PEND_AD);
    mask_hit = (iobus_addr == IRQ_MASK_AD);
    for (int i = 0; i < N_IN; i++) begin
      in_hit[i] = (iobus_addr == chan_addr(IN_BASE, i));
    end
    for (int j = 0; j < N_OUT; j++) begin
      out_hit[j] = (iobus_addr == chan_addr(OUT_BASE, j)) && !pend_hit && !mask_hit;
    end
  end

  // Read mux: later assignments take priority, unmapped addresses read 0.
  always_comb begin
    iobus_in = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (in_hit[i]) iobus_in = 32'(sync_all[i*IN_W +: IN_W]);
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (out_hit[j]) iobus_in = 32'(out_q[j*OUT_W +: OUT_W]);
    end
    if (mask_hit) iobus_in = 32'(mask);
    if (pend_hit) iobus_in = 32'(pend);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (iobus_wr && out_hit[j]) out_q[j*OUT_W +: OUT_W] <= iobus_out[OUT_W-1:0];
      end
    end
  end

  assign out_data = out_q;

  // Synchronisers come out of reset holding 0, so pins already nonzero at
  // release would look like a change; ignore changes until the chain refills.
  assign warm_done = (warm_cnt == WARM_W'(WARMUP_CYCLES));
  assign pend_set  = change & {N_IN{warm_done}};
  assign pend_clr  = (iobus_wr && pend_hit) ? iobus_out[N_IN-1:0] : '0;
  assign irq_any   = |(pend & mask);

  always_ff @(posedge CLK) begin
    if (RST) begin
      warm_cnt  <= '0;
      pend      <= '0;
      mask      <= '0;
      irq_any_q <= 1'b0;
      intr      <= 1'b0;
    end else begin
      if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
      // a set arriving on the same edge as its clear wins
      pend      <= (pend & ~pend_clr) | pend_set;
      if (iobus_wr && mask_hit) mask <= iobus_out[N_IN-1:0];
      irq_any_q <= irq_any;
      intr      <= (IRQ_PULSE != 0) ? (irq_any & ~irq_any_q) : irq_any;
    end
  end

endmodule

// File: tb/tb_otter_mmio_hub.sv
// Scoreboard bench for otter_mmio_hub: a level-mode and a pulse-mode instance
// share all stimulus; expectations are queued with the cycle they apply to and
// a monitor compares them on the falling edge.
module tb_otter_mmio_hub;

  localparam logic [31:0] A_IN0  = 32'h1100_0000;
  localparam logic [31:0] A_OUT0 = 32'h1108_0000;
  localparam logic [31:0] A_OUT1 = 32'h110C_0000;
  localparam logic [31:0] A_PEND = 32'h1120_0000;
  localparam logic [31:0] A_MASK = 32'h1124_0000;
  localparam logic [31:0] A_NONE = 32'h1130_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] in_data;
  logic [31:0] rd_l, rd_p;
  logic [31:0] out_l, out_p;
  logic        intr_l, intr_p;

  always #5 CLK = ~CLK;

  otter_mmio_hub #(.N_IN(2), .IN_W(16), .N_OUT(2), .OUT_W(16), .IRQ_PULSE(0)) dut_l (
    .CLK(CLK), .RST(RST), .iobus_addr(iobus_addr), .iobus_out(iobus_out),
    .iobus_wr(iobus_wr), .iobus_in(rd_l), .in_data(in_data), .out_data(out_l), .intr(intr_l)
  );

  otter_mmio_hub #(.N_IN(2), .IN_W(16), .N_OUT(2), .OUT_W(16), .IRQ_PULSE(1)) dut_p (
    .CLK(CLK), .RST(RST), .iobus_addr(iobus_addr), .iobus_out(iobus_out),
    .iobus_wr(iobus_wr), .iobus_in(rd_p), .in_data(in_data), .out_data(out_p), .intr(intr_p)
  );

  typedef enum int {S_RD, S_OUT, S_INTR, S_PULSE} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_sig(input sig_e s, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = s;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string n);
    iobus_addr = a;
    iobus_wr   = 1'b0;
    expect_sig(S_RD, v, n);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    iobus_addr = a;
    iobus_out  = d;
    iobus_wr   = 1'b1;
    tick();
    iobus_wr   = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    while (!(done && sb.size() == 0)) begin
      @(negedge CLK);
      if (cyc > 4000) begin
        checks++;
        errors++;
        $display("FAIL timeout cyc=%0d pending=%0d required=0", cyc, sb.size());
        break;
      end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t        e;
        logic [31:0] act;
        e = sb.pop_front();
        case (e.sig)
          S_RD:    act = rd_l;
          S_OUT:   act = out_l;
          S_INTR:  act = {31'b0, intr_l};
          default: act = {31'b0, intr_p};
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h required=%h", e.name, cyc, act, e.val);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Stimulus
  initial begin
    RST = 1'b1; iobus_addr = '0; iobus_out = '0; iobus_wr = 1'b0; in_data = '0;
    tick(); tick();
    rd(A_PEND, 32'h0, "rst_pend"); expect_sig(S_OUT, 32'h0, "rst_out");
    expect_sig(S_INTR, 32'h0, "rst_intr"); tick();
    rd(A_MASK, 32'h0, "rst_mask"); RST = 1'b0; tick();
    rd(A_IN0, 32'h0, "rst_in0"); tick(); tick();

    // 1: output register write, read-back, unmapped, ignored writes
    wr(A_OUT0, 32'hDEAD_BEEF);
    expect_sig(S_OUT, 32'h0000_BEEF, "t1_out0"); rd(A_OUT0, 32'h0000_BEEF, "t1_rd_out0"); tick();
    rd(A_NONE, 32'h0, "t1_unmapped"); tick();
    wr(A_OUT1, 32'h1234_5678);
    expect_sig(S_OUT, 32'h5678_BEEF, "t1_out1"); rd(A_OUT1, 32'h0000_5678, "t1_rd_out1"); tick();
    wr(A_IN0, 32'hFFFF_FFFF); wr(A_NONE, 32'hFFFF_FFFF);
    rd(A_IN0, 32'h0, "t1_in_wr_ignored"); expect_sig(S_OUT, 32'h5678_BEEF, "t1_out_kept"); tick();
    rd(A_MASK, 32'h0, "t1_mask_kept"); tick();

    // 2: input change latency, pend, masked intr
    in_data[15:0] = 16'h00A5;
    rd(A_IN0, 32'h0, "t2_before"); tick();                       // edge k
    rd(A_IN0, 32'h0, "t2_k"); tick();                            // k+1
    rd(A_IN0, 32'h0000_00A5, "t2_k1"); expect_sig(S_INTR, 0, "t2_intr_k1"); tick(); // k+2
    rd(A_PEND, 32'h1, "t2_pend"); tick();                        // k+3
    rd(A_PEND, 32'h1, "t2_pend_hold"); expect_sig(S_INTR, 0, "t2_intr_masked"); tick();

    // 3: unmask pending bit, clear, new change, set-beats-clear
    wr(A_MASK, 32'h1);
    expect_sig(S_INTR, 0, "t3_unmask_m"); rd(A_MASK, 32'h1, "t3_mask"); tick();
    expect_sig(S_INTR, 1, "t3_unmask_intr");
    wr(A_PEND, 32'h1);
    rd(A_PEND, 32'h0, "t3_clr"); expect_sig(S_INTR, 1, "t3_intr_lag"); tick();
    expect_sig(S_INTR, 0, "t3_intr_clr"); tick();
    in_data[15:0] = 16'h005A;
    tick(); tick();                                              // k, k+1
    expect_sig(S_INTR, 0, "t3_intr_k1"); tick();                 // k+2
    rd(A_PEND, 32'h1, "t3_pend2"); expect_sig(S_INTR, 0, "t3_intr_k2"); tick(); // k+3
    expect_sig(S_INTR, 1, "t3_intr_k3"); tick();
    in_data[15:0] = 16'h003C;
    tick(); tick();                                              // k, k+1
    wr(A_PEND, 32'h1);                                           // clear on edge k+2 with the set
    rd(A_PEND, 32'h1, "t3_set_wins"); tick();
    wr(A_PEND, 32'h1);
    rd(A_PEND, 32'h0, "t3_clr2"); tick();
    wr(A_MASK, 32'h0); tick();
    expect_sig(S_INTR, 0, "t3_intr_off"); tick();

    // 4: pins nonzero through reset release, warm-up suppression
    in_data = 32'h0000_FFFF;
    RST = 1'b1; tick(); tick();
    expect_sig(S_OUT, 32'h0, "t4_out_rst"); RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd(A_PEND, 32'h0, "t4_warmup"); tick();
    end
    rd(A_IN0, 32'h0000_FFFF, "t4_in0"); tick();
    in_data[15:0] = 16'h0000;
    tick(); tick(); tick();
    rd(A_PEND, 32'h1, "t4_pend_after"); tick();

    // 5: pulse mode, one pulse while OR stays high, re-arm after clear
    wr(A_PEND, 32'h3);
    wr(A_MASK, 32'h3);
    in_data[15:0] = 16'h1111;
    tick(); tick();                                              // k, k+1
    expect_sig(S_PULSE, 0, "t5_k1"); tick();                     // k+2
    expect_sig(S_PULSE, 0, "t5_k2"); tick();                     // k+3
    expect_sig(S_PULSE, 1, "t5_pulse1"); expect_sig(S_INTR, 1, "t5_level"); tick();
    expect_sig(S_PULSE, 0, "t5_pulse1_end");
    in_data[31:16] = 16'h2222;
    for (int i = 0; i < 6; i++) begin
      expect_sig(S_PULSE, 0, "t5_no_second"); tick();
    end
    rd(A_PEND, 32'h3, "t5_pend_both"); tick();
    wr(A_PEND, 32'h3); tick(); tick();
    rd(A_PEND, 32'h0, "t5_cleared"); expect_sig(S_PULSE, 0, "t5_idle"); tick();
    in_data[31:16] = 16'h0000;
    tick(); tick();                                              // k, k+1
    expect_sig(S_PULSE, 0, "t5_r_k1"); tick();                   // k+2
    expect_sig(S_PULSE, 0, "t5_r_k2"); tick();                   // k+3
    expect_sig(S_PULSE, 1, "t5_pulse2"); tick();
    expect_sig(S_PULSE, 0, "t5_pulse2_end"); tick();

    // 6: reset the cycle after a pin change
    wr(A_OUT0, 32'h0000_55AA);
    wr(A_MASK, 32'h1);
    in_data[15:0] = 16'h1234;
    tick();                                                      // edge k
    RST = 1'b1; tick();                                          // k+1 resets
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd(A_PEND, 32'h0, "t6_pend"); expect_sig(S_INTR, 0, "t6_intr"); tick();
    end
    rd(A_OUT0, 32'h0, "t6_out0"); expect_sig(S_OUT, 32'h0, "t6_out_data"); tick();
    rd(A_OUT1, 32'h0, "t6_out1"); tick();
    rd(A_MASK, 32'h0, "t6_mask"); tick();
    tick();
    done = 1'b1;
  end

endmodule
